// File: rtl/uart_bus_regs.sv
// ---------------------------------------------------------------------------
// uart_bus_regs
//
// Bus-side register front end for the UART core. Responds on the Ibex data
// bus (req/gnt/rvalid), hands characters to the transmitter through a
// one-entry holding register, and buffers received characters in a small
// FIFO with sticky overrun / parity error flags.
//
// Register map (addr[3:2]):
//   0 TXDATA  W: load character (be[0]); reads 0
//   1 RXDATA  R: pop FIFO head (0 when empty); writes ignored
//   2 STATUS  R: {parity_err, rx_overrun, rx_full, rx_not_empty, tx_busy}
//             W: be[0] write-1-to-clear of bits [4:3]
//   3 reserved, reads 0
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   data_*                  Ibex data bus responder (gnt is combinational)
//   tx_data_o/tx_data_vld_o character and request to the transmitter
//   tx_active_i             transmitter busy
//   rx_data_i/rx_data_vld_i received character and its one-cycle strobe
//   rx_parity_err_i         parity error, qualified by rx_data_vld_i
// ---------------------------------------------------------------------------
module uart_bus_regs #(
    parameter int DATA_BITS     = 8,
    parameter int RX_FIFO_DEPTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 data_req_i,
    output logic                 data_gnt_o,
    output logic                 data_rvalid_o,
    input  logic                 data_we_i,
    input  logic [3:0]           data_be_i,
    input  logic [31:0]          data_addr_i,
    input  logic [31:0]          data_wdata_i,
    output logic [31:0]          data_rdata_o,
    output logic                 data_err_o,
    output logic [DATA_BITS-1:0] tx_data_o,
    output logic                 tx_data_vld_o,
    input  logic                 tx_active_i,
    input  logic [DATA_BITS-1:0] rx_data_i,
    input  logic                 rx_data_vld_i,
    input  logic                 rx_parity_err_i
);

    localparam int          PW          = $clog2(RX_FIFO_DEPTH);
    localparam logic [PW:0] DEPTH_CNT   = (PW+1)'(RX_FIFO_DEPTH);
    localparam logic [1:0]  ADDR_TX     = 2'd0;
    localparam logic [1:0]  ADDR_RX     = 2'd1;
    localparam logic [1:0]  ADDR_STATUS = 2'd2;

    // State
    logic                 tx_pending_reg;
    logic [DATA_BITS-1:0] tx_data_reg;
    logic [DATA_BITS-1:0] fifo_mem [RX_FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_reg;
    logic [PW-1:0]        rd_ptr_reg;
    logic [PW:0]          count_reg;
    logic                 overrun_reg;
    logic                 parity_reg;
    logic                 rvalid_reg;
    logic [31:0]          rdata_reg;

    // Decode and handshake
    logic [1:0]           addr_sel;
    logic                 tx_busy;
    logic                 tx_wr_req;
    logic                 gnt;
    logic                 wr_acc;
    logic                 rd_acc;
    logic                 rx_empty;
    logic                 rx_full;
    logic                 pop;
    logic                 push;
    logic                 overrun_set;
    logic                 parity_set;
    logic                 w1c;
    logic [31:0]          status_word;
    logic [DATA_BITS-1:0] rx_head;
    logic [31:0]          rd_value;
    logic                 unused_bits;

    assign addr_sel  = data_addr_i[3:2];
    assign tx_busy   = tx_pending_reg | tx_active_i;
    assign tx_wr_req = data_req_i & data_we_i & (addr_sel == ADDR_TX);

    // Only a TXDATA write can be stalled: it waits until the holding
    // register is free and the transmitter has gone idle.
    assign gnt    = data_req_i & ~(tx_wr_req & tx_busy);
    assign wr_acc = gnt & data_we_i;
    assign rd_acc = gnt & ~data_we_i;

    assign rx_empty = (count_reg == '0);
    assign rx_full  = (count_reg == DEPTH_CNT);

    // A pop in the same cycle frees a slot, so a push into a full FIFO
    // still succeeds then; an empty FIFO never pops, so the push survives.
    assign pop         = rd_acc & (addr_sel == ADDR_RX) & ~rx_empty;
    assign push        = rx_data_vld_i & (~rx_full | pop);
    assign overrun_set = rx_data_vld_i & rx_full & ~pop;
    assign parity_set  = rx_data_vld_i & rx_parity_err_i;
    assign w1c         = wr_acc & (addr_sel == ADDR_STATUS) & data_be_i[0];

    assign status_word = {27'b0, parity_reg, overrun_reg, rx_full, ~rx_empty, tx_busy};
    assign rx_head     = fifo_mem[rd_ptr_reg];

    always_comb begin
        rd_value = '0;
        case (addr_sel)
            ADDR_RX: begin
                if (!rx_empty) begin
                    rd_value = {{(32-DATA_BITS){1'b0}}, rx_head};
                end
            end
            ADDR_STATUS: rd_value = status_word;
            default:     rd_value = '0;
        endcase
    end

    // Bus response: one registered beat per grant; rdata is zero except
    // during the rvalid cycle of a read.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_reg <= 1'b0;
            rdata_reg  <= '0;
        end else begin
            rvalid_reg <= gnt;
            rdata_reg  <= rd_acc ? rd_value : '0;
        end
    end

    // TX holding register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_pending_reg <= 1'b0;
            tx_data_reg    <= '0;
        end else if (wr_acc && addr_sel == ADDR_TX && data_be_i[0]) begin
            tx_pending_reg <= 1'b1;
            tx_data_reg    <= data_wdata_i[DATA_BITS-1:0];
        end else if (tx_pending_reg && tx_active_i) begin
            tx_pending_reg <= 1'b0;
        end
    end

    // RX FIFO storage (no reset needed: count gates every read)
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= rx_data_i;
        end
    end

    // RX FIFO pointers and occupancy
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Sticky flags: clear first, then set, so a same-cycle set wins.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            overrun_reg <= 1'b0;
            parity_reg  <= 1'b0;
        end else begin
            overrun_reg <= (overrun_reg & ~(w1c & data_wdata_i[3])) | overrun_set;
            parity_reg  <= (parity_reg  & ~(w1c & data_wdata_i[4])) | parity_set;
        end
    end

    assign data_gnt_o    = gnt;
    assign data_rvalid_o = rvalid_reg;
    assign data_rdata_o  = rdata_reg;
    assign data_err_o    = 1'b0;
    assign tx_data_o     = tx_data_reg;
    assign tx_data_vld_o = tx_pending_reg;

    // Address/byte-enable/data bits that the register map never decodes
    assign unused_bits = ^{data_addr_i[31:4], data_addr_i[1:0], data_be_i[3:1],
                           data_wdata_i[31:DATA_BITS]};

endmodule

// File: tb/tb_uart_bus_regs.sv
// ---------------------------------------------------------------------------
// tb_uart_bus_regs
//
// Self-checking bench for uart_bus_regs. A transaction-level model (queue
// for the RX FIFO, flags for TX/sticky state) predicts grant, response and
// TX outputs every cycle; directed sequences add fixed expected values for
// the handshake, stall, FIFO ordering/overrun, parity and reset cases, then
// a randomized phase exercises the same rules.
// ---------------------------------------------------------------------------
module tb_uart_bus_regs;

    localparam int DB    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req;
    logic          gnt_o;
    logic          rvalid_o;
    logic          we;
    logic [3:0]    be;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [31:0]   rdata_o;
    logic          err_o;
    logic [DB-1:0] txd_o;
    logic          txv_o;
    logic          tx_active;
    logic [DB-1:0] rx_d;
    logic          rx_vld;
    logic          rx_par;

    always #5 clk = ~clk;

    uart_bus_regs #(
        .DATA_BITS     (DB),
        .RX_FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .data_req_i      (req),
        .data_gnt_o      (gnt_o),
        .data_rvalid_o   (rvalid_o),
        .data_we_i       (we),
        .data_be_i       (be),
        .data_addr_i     (addr),
        .data_wdata_i    (wdata),
        .data_rdata_o    (rdata_o),
        .data_err_o      (err_o),
        .tx_data_o       (txd_o),
        .tx_data_vld_o   (txv_o),
        .tx_active_i     (tx_active),
        .rx_data_i       (rx_d),
        .rx_data_vld_i   (rx_vld),
        .rx_parity_err_i (rx_par)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state
    logic [7:0]  m_q [$];
    logic        m_pend = 1'b0;
    logic [7:0]  m_txd  = 8'h00;
    logic        m_ovr  = 1'b0;
    logic        m_par  = 1'b0;
    logic        m_rvalid = 1'b0;
    logic [31:0] m_rdata  = 32'h0;
    logic        dut_gnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_status();
        return {27'b0, m_par, m_ovr, (m_q.size() == DEPTH), (m_q.size() != 0), (m_pend | tx_active)};
    endfunction

    // One clock cycle with the currently driven inputs: predict, compare
    // the combinational grant, advance the model, then compare the
    // registered outputs just after the edge.
    task automatic tick();
        logic        g;
        logic [31:0] rd;
        logic [1:0]  a;
        #2;
        a  = addr[3:2];
        g  = req && !(we && a == 2'd0 && (m_pend || tx_active));
        dut_gnt = gnt_o;
        check_eq("gnt", 32'(gnt_o), 32'(g));
        check_eq("err", 32'(err_o), 32'h0);
        rd = 32'h0;
        if (g && !we) begin
            if (a == 2'd1 && m_q.size() != 0) rd = 32'(m_q[0]);
            else if (a == 2'd2)               rd = m_status();
        end
        if (rst) begin
            m_q.delete();
            m_pend = 1'b0; m_txd = 8'h00; m_ovr = 1'b0; m_par = 1'b0;
            m_rvalid = 1'b0; m_rdata = 32'h0;
        end else begin
            if (g && we && a == 2'd2 && be[0]) begin
                if (wdata[3]) m_ovr = 1'b0;
                if (wdata[4]) m_par = 1'b0;
            end
            if (g && we && a == 2'd0 && be[0]) begin
                m_txd  = wdata[7:0];
                m_pend = 1'b1;
            end else if (m_pend && tx_active) begin
                m_pend = 1'b0;
            end
            if (g && !we && a == 2'd1 && m_q.size() != 0) void'(m_q.pop_front());
            if (rx_vld) begin
                if (rx_par) m_par = 1'b1;
                if (m_q.size() < DEPTH) m_q.push_back(rx_d);
                else                    m_ovr = 1'b1;
            end
            m_rvalid = g;
            m_rdata  = rd;
        end
        @(posedge clk);
        #1;
        check_eq("rvalid", 32'(rvalid_o), 32'(m_rvalid));
        check_eq("rdata",  rdata_o, m_rdata);
        check_eq("tx_data", 32'(txd_o), 32'(m_txd));
        check_eq("tx_vld",  32'(txv_o), 32'(m_pend));
    endtask

    task automatic idle();
        req = 1'b0; we = 1'b0; be = 4'h0; addr = 32'h0; wdata = 32'h0;
        rx_vld = 1'b0; rx_par = 1'b0; rx_d = '0;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] v);
        req = 1'b1; we = 1'b0; addr = a; be = 4'hf;
        tick();
        v = rdata_o;
        req = 1'b0;
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        req = 1'b1; we = 1'b1; addr = a; wdata = d; be = b;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (dut_gnt) break;
        end
        check_eq("wr_grant", 32'(dut_gnt), 32'h1);
        req = 1'b0; we = 1'b0;
    endtask

    task automatic rx_push(input logic [7:0] d, input logic p);
        rx_vld = 1'b1; rx_d = d; rx_par = p;
        tick();
        rx_vld = 1'b0; rx_par = 1'b0;
    endtask

    initial begin
        logic [31:0] v;
        int          n;
        idle();
        tx_active = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check_eq("rst_rvalid", 32'(rvalid_o), 32'h0);
        check_eq("rst_txvld",  32'(txv_o), 32'h0);
        bus_rd(32'h8, v);
        check_eq("rst_status", v, 32'h0);

        // TX handshake: request visible for exactly 3 cycles
        bus_wr(32'h0, 32'h000000A5, 4'h1);
        check_eq("tx_a5", 32'(txd_o), 32'hA5);
        n = int'(txv_o);
        tick(); n += int'(txv_o);
        tick(); n += int'(txv_o);
        tx_active = 1'b1;
        tick(); n += int'(txv_o);
        check_eq("tx_vld_cycles", 32'(n), 32'd3);
        bus_rd(32'h8, v);
        check_eq("tx_busy_active", v, 32'h1);

        // TX stall while the transmitter is active
        req = 1'b1; we = 1'b1; addr = 32'h0; wdata = 32'h3C; be = 4'h1;
        n = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (!dut_gnt) n++;
        end
        check_eq("stall_cycles", 32'(n), 32'd14);
        tx_active = 1'b0;
        tick();
        check_eq("stall_release", 32'(dut_gnt), 32'h1);
        check_eq("stall_rvalid", 32'(rvalid_o), 32'h1);
        check_eq("tx_3c", 32'(txd_o), 32'h3C);
        idle();
        bus_rd(32'h8, v);
        check_eq("tx_pending_busy", v, 32'h1);
        tx_active = 1'b1; tick();
        tx_active = 1'b0; tick();
        bus_rd(32'h8, v);
        check_eq("tx_idle", v, 32'h0);

        // RX ordering and overrun
        for (int i = 1; i <= 5; i++) rx_push(8'(8'h11 * i), 1'b0);
        bus_rd(32'h8, v);
        check_eq("rx_full_status", v, 32'h0E);
        for (int i = 1; i <= 5; i++) begin
            bus_rd(32'h4, v);
            check_eq("rx_order", v, (i <= 4) ? 32'(8'h11 * i) : 32'h0);
        end
        bus_rd(32'h8, v);
        check_eq("rx_ovr_status", v, 32'h08);
        bus_wr(32'h8, 32'h08, 4'h1);
        bus_rd(32'h8, v);
        check_eq("ovr_cleared", v, 32'h0);

        // Push and pop in the same cycle while full
        for (int i = 1; i <= 4; i++) rx_push(8'(i), 1'b0);
        rx_vld = 1'b1; rx_d = 8'h99;
        bus_rd(32'h4, v);
        rx_vld = 1'b0;
        check_eq("pp_first", v, 32'h1);
        bus_rd(32'h8, v);
        check_eq("pp_no_ovr", v, 32'h06);
        for (int i = 2; i <= 5; i++) begin
            bus_rd(32'h4, v);
            check_eq("pp_order", v, (i <= 4) ? 32'(i) : 32'h99);
        end

        // Parity error, clear, and clear racing a new error
        rx_push(8'h7E, 1'b1);
        bus_rd(32'h8, v);
        check_eq("par_status", v, 32'h12);
        bus_rd(32'h4, v);
        check_eq("par_data", v, 32'h7E);
        bus_wr(32'h8, 32'h10, 4'h1);
        bus_rd(32'h8, v);
        check_eq("par_cleared", v, 32'h0);
        rx_vld = 1'b1; rx_d = 8'h5A; rx_par = 1'b1;
        bus_wr(32'h8, 32'h10, 4'h1);
        rx_vld = 1'b0; rx_par = 1'b0;
        bus_rd(32'h8, v);
        check_eq("par_set_wins", v, 32'h12);
        bus_wr(32'h8, 32'h10, 4'h1);
        bus_rd(32'h4, v);

        // Reset mid-operation, with a read granted in the reset cycle
        rx_push(8'hC1, 1'b0);
        rx_push(8'hC2, 1'b0);
        bus_wr(32'h0, 32'h77, 4'h1);
        rst = 1'b1; req = 1'b1; we = 1'b0; addr = 32'h8;
        tick();
        rst = 1'b0; idle();
        check_eq("mid_rst_rvalid", 32'(rvalid_o), 32'h0);
        check_eq("mid_rst_rdata", rdata_o, 32'h0);
        check_eq("mid_rst_txvld", 32'(txv_o), 32'h0);
        check_eq("mid_rst_txd", 32'(txd_o), 32'h0);
        bus_rd(32'h8, v);
        check_eq("mid_rst_status", v, 32'h0);
        bus_rd(32'h4, v);
        check_eq("mid_rst_rx", v, 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            req       = ($urandom_range(0, 99) < 60);
            we        = $urandom_range(0, 1) == 1;
            addr      = $urandom;
            be        = 4'($urandom);
            wdata     = $urandom;
            rx_vld    = ($urandom_range(0, 99) < 40);
            rx_d      = 8'($urandom);
            rx_par    = ($urandom_range(0, 99) < 10);
            tx_active = ($urandom_range(0, 99) < 30);
            tick();
        end
        idle();
        tx_active = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
